match_detector: RTL and testbench

//  Streaming pattern detector; this block generates match_flag and halt_signal for controller_fsm.

---
 rtl/match_detector.sv | 137 +++++++++++++
 tb/tb_match_detector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_detector.sv
// ----------------------------------------------------------------------------
// match_detector
//   Streaming pattern detector that feeds controller_fsm. Symbols arrive over a
//   valid/ready handshake and slide into a PAT_LEN-symbol window. Every time
//   the window equals PATTERN, match_flag pulses for one cycle. The scan ends
//   (halt_signal high) when HALT_SYM is accepted or when match_count reaches
//   MAX_MATCH. A start pulse clears everything and begins a new scan.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous reset, active-low
//   start        1-cycle pulse: clear and begin a scan (ignored while scanning)
//   sym_valid    sym_data holds a symbol
//   sym_data     input symbol, SYM_W bits
//   sym_ready    detector accepts a symbol this cycle (high only in SCAN)
//   match_flag   registered 1-cycle pulse per detected match
//   halt_signal  level: scan finished, held until the next start
//   match_count  matches found in the current scan, saturating at MAX_MATCH
//   busy         high while scanning
// ----------------------------------------------------------------------------
module match_detector #(
    parameter int                         SYM_W     = 8,
    parameter int                         PAT_LEN   = 4,
    parameter logic [SYM_W*PAT_LEN-1:0]   PATTERN   = 32'h41424344,
    parameter logic [SYM_W-1:0]           HALT_SYM  = 8'h00,
    parameter int                         MAX_MATCH = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    output logic             match_flag,
    output logic             halt_signal,
    output logic [7:0]       match_count,
    output logic             busy
);

    localparam int               WIN_W    = SYM_W * PAT_LEN;
    localparam int               FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [7:0]       MAX_C    = 8'(MAX_MATCH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t             state, state_next;
    logic [WIN_W-1:0]   window;
    logic [WIN_W-1:0]   window_next;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_next;
    logic               accept;
    logic               is_halt_sym;
    logic               shift_en;
    logic               hit;
    logic               at_limit;
    logic               enter_scan;

    // Fill count saturates at PAT_LEN: once the window is full it stays "full".
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
        return (v == FILL_MAX) ? v : v + FILL_W'(1);
    endfunction

    // Match counter never wraps past MAX_MATCH.
    function automatic logic [7:0] count_inc(input logic [7:0] v);
        return (v == MAX_C) ? v : v + 8'd1;
    endfunction

    // ---- handshake / window evaluation (combinational) ----
    always_comb begin
        accept      = sym_valid && sym_ready;
        is_halt_sym = (sym_data == HALT_SYM);
        shift_en    = accept && !is_halt_sym;
        window_next = {window[WIN_W-SYM_W-1:0], sym_data};
        fill_next   = fill_inc(fill);
        // The match is judged on the window as it will be after this symbol
        // shifts in; the fill guard keeps stale zeros from ever matching.
        hit         = shift_en && (fill_next >= FILL_MAX) && (window_next == PATTERN);
        at_limit    = hit && (count_inc(match_count) == MAX_C);
        enter_scan  = start && (state != SCAN);
    end

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: if ((accept && is_halt_sym) || at_limit) state_next = HALT;
            HALT: if (start) state_next = SCAN;
            default: state_next = IDLE;
        endcase
    end

    // ---- FSM outputs ----
    always_comb begin
        sym_ready   = (state == SCAN);
        busy        = (state == SCAN);
        halt_signal = (state == HALT);
    end

    // ---- window, fill count, match counter and match pulse registers ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window      <= '0;
            fill        <= '0;
            match_count <= 8'd0;
            match_flag  <= 1'b0;
        end else begin
            match_flag <= hit;
            if (enter_scan) begin
                window      <= '0;
                fill        <= '0;
                match_count <= 8'd0;
            end else if (shift_en) begin
                window <= window_next;
                fill   <= fill_next;
                if (hit) begin
                    match_count <= count_inc(match_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_match_detector.sv
// ----------------------------------------------------------------------------
// tb_match_detector
//   Three detector instances share one stimulus stream: the default
//   configuration, PATTERN="ABAB", and MAX_MATCH=2. Each instance has its own
//   reference model that keeps the list of symbols accepted since the last
//   start and decides matches by comparing the newest PAT_LEN entries with the
//   pattern. Outputs are compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_match_detector;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       sym_valid;
    logic [7:0] sym_data;

    logic       rdy [NDUT];
    logic       mf  [NDUT];
    logic       hs  [NDUT];
    logic       bz  [NDUT];
    logic [7:0] mc  [NDUT];

    int checks   = 0;
    int failures = 0;

    // reference model state: 0 idle, 1 scanning, 2 halted
    int          m_state [NDUT];
    int          m_cnt   [NDUT];
    logic        m_flag  [NDUT];
    logic [7:0]  hist    [NDUT][$];
    logic [31:0] m_pat   [NDUT] = '{32'h41424344, 32'h41424142, 32'h41424344};
    int          m_max   [NDUT] = '{255, 255, 2};

    always #5 clk = ~clk;

    match_detector u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .sym_valid(sym_valid),
        .sym_data(sym_data), .sym_ready(rdy[0]), .match_flag(mf[0]),
        .halt_signal(hs[0]), .match_count(mc[0]), .busy(bz[0])
    );

    match_detector #(.PATTERN(32'h41424142)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .sym_valid(sym_valid),
        .sym_data(sym_data), .sym_ready(rdy[1]), .match_flag(mf[1]),
        .halt_signal(hs[1]), .match_count(mc[1]), .busy(bz[1])
    );

    match_detector #(.MAX_MATCH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .sym_valid(sym_valid),
        .sym_data(sym_data), .sym_ready(rdy[2]), .match_flag(mf[2]),
        .halt_signal(hs[2]), .match_count(mc[2]), .busy(bz[2])
    );

    task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    function automatic bit model_hit(input int k);
        int n;
        logic [31:0] p;
        logic [7:0] e;
        n = hist[k].size();
        if (n < 4) return 1'b0;
        p = m_pat[k];
        for (int i = 0; i < 4; i++) begin
            e = p[31-8*i -: 8];
            if (hist[k][n-4+i] != e) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_state[k] = 0;
            m_cnt[k]   = 0;
            m_flag[k]  = 1'b0;
            hist[k].delete();
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NDUT; k++) begin
            m_flag[k] = 1'b0;
            if (m_state[k] != 1) begin
                if (start) begin
                    m_state[k] = 1;
                    m_cnt[k]   = 0;
                    hist[k].delete();
                end
            end else if (sym_valid) begin
                if (sym_data == 8'h00) begin
                    m_state[k] = 2;
                end else begin
                    hist[k].push_back(sym_data);
                    if (hist[k].size() > 8) void'(hist[k].pop_front());
                    if (model_hit(k)) begin
                        m_cnt[k]++;
                        m_flag[k] = 1'b1;
                        if (m_cnt[k] == m_max[k]) m_state[k] = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            chk("sym_ready",   k, {7'd0, rdy[k]}, {7'd0, m_state[k] == 1});
            chk("busy",        k, {7'd0, bz[k]},  {7'd0, m_state[k] == 1});
            chk("halt_signal", k, {7'd0, hs[k]},  {7'd0, m_state[k] == 2});
            chk("match_flag",  k, {7'd0, mf[k]},  {7'd0, m_flag[k]});
            chk("match_count", k, mc[k], 8'(m_cnt[k]));
        end
    endtask

    // One clock: inputs set before the rising edge, outputs checked at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [7:0] s);
        sym_valid = 1'b1;
        sym_data  = s;
        cycle();
        sym_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (gaps) cycle();
        end
    endtask

    logic [7:0] syms [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h42, 8'h78};

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        sym_valid = 1'b0;
        sym_data  = 8'h00;
        model_reset();
        @(negedge clk);
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();

        // stream x,A,B,C,D,y
        pulse_start();
        send(8'h78);
        send_str("ABC", 1'b0);
        send("D");
        chk("t1_flag",  0, {7'd0, mf[0]}, 8'd1);
        chk("t1_count", 0, mc[0], 8'd1);
        chk("t1_halt",  0, {7'd0, hs[0]}, 8'd0);
        send(8'h79);
        chk("t1_flag_off", 0, {7'd0, mf[0]}, 8'd0);

        // scan ends on ...A, restart, then B,C,D must not match
        send("A");
        send(8'h00);
        pulse_start();
        send_str("BCD", 1'b0);
        chk("t2_flag",  0, {7'd0, mf[0]}, 8'd0);
        chk("t2_count", 0, mc[0], 8'd0);

        // overlapping ABAB with valid gaps
        send_str("ABABAB", 1'b1);
        chk("t3_count", 1, mc[1], 8'd2);

        // HALT_SYM, ignored symbols, restart
        send(8'h00);
        chk("t4_halt",  0, {7'd0, hs[0]}, 8'd1);
        chk("t4_ready", 0, {7'd0, rdy[0]}, 8'd0);
        send_str("ABCD", 1'b0);
        chk("t4_flag",  0, {7'd0, mf[0]}, 8'd0);
        chk("t4_held",  1, mc[1], 8'd2);
        pulse_start();
        chk("t4_halt_off", 1, {7'd0, hs[1]}, 8'd0);
        chk("t4_busy",     1, {7'd0, bz[1]}, 8'd1);
        chk("t4_cleared",  1, mc[1], 8'd0);

        // MAX_MATCH=2 instance
        send_str("ABCDABCD", 1'b0);
        chk("t5_flag",  2, {7'd0, mf[2]}, 8'd1);
        chk("t5_halt",  2, {7'd0, hs[2]}, 8'd1);
        chk("t5_count", 2, mc[2], 8'd2);
        chk("t5_ready", 2, {7'd0, rdy[2]}, 8'd0);
        chk("t5_cont",  0, mc[0], 8'd2);

        // asynchronous reset mid-pattern
        pulse_start();
        send_str("ABC", 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("t6_ready", k, {7'd0, rdy[k]}, 8'd0);
            chk("t6_flag",  k, {7'd0, mf[k]},  8'd0);
            chk("t6_halt",  k, {7'd0, hs[k]},  8'd0);
            chk("t6_busy",  k, {7'd0, bz[k]},  8'd0);
            chk("t6_count", k, mc[k], 8'd0);
        end
        @(negedge clk);
        repeat (2) cycle();
        reset_n = 1'b1;
        send("D");
        chk("t6_idle_ready", 0, {7'd0, rdy[0]}, 8'd0);
        chk("t6_idle_flag",  0, {7'd0, mf[0]},  8'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            start     = ($urandom_range(0, 39) == 0);
            sym_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) sym_data = 8'h00;
            else sym_data = syms[$urandom_range(0, 5)];
            cycle();
        end
        start     = 1'b0;
        sym_valid = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
